// File: rtl/bus_arbiter2_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arbiter2_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2
   } arb_state_t;

   localparam int unsigned ARB_TIMEOUT = 1024;

   function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/bus_arbiter2_timeout.sv
// Per-transfer watchdog: counts unanswered strobe cycles, pulses tmo at TIMEOUT-1.
module bus_timeout
   import bus_arbiter2_pkg::*;
#(
   parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic s_ready,
   input  logic clear,
   output logic tmo
);

   localparam int unsigned   CW   = tmo_cnt_width(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // A ready in the final cycle wins over the timeout.
   assign tmo = strobe & ~s_ready & (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear || !strobe || s_ready || tmo) count <= '0;
      else                                           count <= count + 1'b1;
   end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master fixed-priority bus arbiter with transfer-boundary handoff and timeout.
module bus_arbiter2
   import bus_arbiter2_pkg::*;
#(
   parameter int unsigned TIMEOUT = ARB_TIMEOUT,
   parameter int unsigned HIPRIO  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   output logic        m0_gnt,
   output logic        m0_hrd,
   input  logic [31:0] m0_a,
   input  logic [31:0] m0_d,
   input  logic        m0_we,
   input  logic        m0_rd,
   output logic [31:0] m0_spo,
   output logic        m0_ready,
   input  logic        m1_req,
   output logic        m1_gnt,
   output logic        m1_hrd,
   input  logic [31:0] m1_a,
   input  logic [31:0] m1_d,
   input  logic        m1_we,
   input  logic        m1_rd,
   output logic [31:0] m1_spo,
   output logic        m1_ready,
   output logic [31:0] s_a,
   output logic [31:0] s_d,
   output logic        s_we,
   output logic        s_rd,
   input  logic [31:0] s_spo,
   input  logic        s_ready,
   output logic        bus_err,
   output logic [31:0] err_addr
);

   arb_state_t  state, state_nxt;
   logic        busy, tmo, strobe, pending, grant_change;
   logic        sel_we, sel_rd;
   logic [31:0] sel_a, sel_d;

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (m0_req && m1_req) state_nxt = (HIPRIO == 0) ? ARB_GNT0 : ARB_GNT1;
            else if (m0_req)      state_nxt = ARB_GNT0;
            else if (m1_req)      state_nxt = ARB_GNT1;
         end
         ARB_GNT0: if (!m0_req) state_nxt = m1_req ? ARB_GNT1 : ARB_IDLE;
         ARB_GNT1: if (!m1_req) state_nxt = m0_req ? ARB_GNT0 : ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
   end

   assign grant_change = (state_nxt != state);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         m0_gnt   <= 1'b0;
         m1_gnt   <= 1'b0;
         busy     <= 1'b0;
         bus_err  <= 1'b0;
         err_addr <= '0;
      end else begin
         state  <= state_nxt;
         m0_gnt <= (state_nxt == ARB_GNT0);
         m1_gnt <= (state_nxt == ARB_GNT1);
         if (grant_change || s_ready || tmo) busy <= 1'b0;
         else if (pending)                   busy <= 1'b1;
         bus_err <= tmo;
         if (tmo) err_addr <= s_a;
      end
   end

   // Registered grants select the source, so strobes only pass once gnt is visible.
   always_comb begin
      sel_we = 1'b0;
      sel_rd = 1'b0;
      sel_a  = '0;
      sel_d  = '0;
      if (m0_gnt) begin
         sel_we = m0_we;
         sel_rd = m0_rd;
         sel_a  = m0_a;
         sel_d  = m0_d;
      end else if (m1_gnt) begin
         sel_we = m1_we;
         sel_rd = m1_rd;
         sel_a  = m1_a;
         sel_d  = m1_d;
      end
   end

   assign strobe  = sel_we | sel_rd;
   assign pending = strobe & ~s_ready;

   bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .strobe  (strobe),
      .s_ready (s_ready),
      .clear   (grant_change),
      .tmo     (tmo)
   );

   assign s_a  = sel_a;
   assign s_d  = sel_d;
   assign s_we = sel_we & ~tmo;
   assign s_rd = sel_rd & ~tmo;

   assign m0_spo   = (m0_gnt && !tmo) ? s_spo : '0;
   assign m1_spo   = (m1_gnt && !tmo) ? s_spo : '0;
   assign m0_ready = m0_gnt & (s_ready | tmo);
   assign m1_ready = m1_gnt & (s_ready | tmo);
   assign m0_hrd   = m0_gnt & m1_req & ~busy & ~pending;
   assign m1_hrd   = m1_gnt & m0_req & ~busy & ~pending;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2 with a rule-level reference model checked every cycle.
module tb_bus_arbiter2;

   localparam int unsigned TMO = 16;
   localparam int          HI  = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req [2];
   logic        we  [2];
   logic        rd  [2];
   logic [31:0] a   [2];
   logic [31:0] d   [2];
   logic        gnt [2];
   logic        hrd [2];
   logic        ready [2];
   logic [31:0] spo [2];
   logic [31:0] s_a, s_d, s_spo, err_addr;
   logic        s_we, s_rd, s_ready, bus_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bus_arbiter2 #(.TIMEOUT(TMO), .HIPRIO(HI)) dut (
      .clk(clk), .rst(rst),
      .m0_req(req[0]), .m0_gnt(gnt[0]), .m0_hrd(hrd[0]), .m0_a(a[0]), .m0_d(d[0]),
      .m0_we(we[0]), .m0_rd(rd[0]), .m0_spo(spo[0]), .m0_ready(ready[0]),
      .m1_req(req[1]), .m1_gnt(gnt[1]), .m1_hrd(hrd[1]), .m1_a(a[1]), .m1_d(d[1]),
      .m1_we(we[1]), .m1_rd(rd[1]), .m1_spo(spo[1]), .m1_ready(ready[1]),
      .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
      .bus_err(bus_err), .err_addr(err_addr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 = nobody), unanswered-strobe cycles, transfer in flight.
   int          owner = -1;
   int          waited = 0;
   bit          outstanding = 1'b0;
   bit          err_pulse = 1'b0;
   logic [31:0] err_a = '0;
   bit          model_ok = 1'b0;

   function automatic bit m_strobe();
      if (owner < 0) return 1'b0;
      return we[owner] | rd[owner];
   endfunction

   function automatic bit m_tmo();
      return m_strobe() && !s_ready && (waited == int'(TMO) - 1);
   endfunction

   function automatic logic [31:0] m_addr();
      if (owner < 0) return '0;
      return a[owner];
   endfunction

   function automatic int next_owner();
      if (owner < 0) begin
         if (req[0] && req[1]) return HI;
         if (req[0]) return 0;
         if (req[1]) return 1;
         return -1;
      end
      if (req[owner]) return owner;
      return req[1-owner] ? 1 - owner : -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         owner       <= -1;
         waited      <= 0;
         outstanding <= 1'b0;
         err_pulse   <= 1'b0;
         err_a       <= '0;
         model_ok    <= 1'b1;
      end else if (model_ok) begin
         owner     <= next_owner();
         err_pulse <= m_tmo();
         if (m_tmo()) err_a <= m_addr();
         waited <= (next_owner() != owner || !m_strobe() || s_ready || m_tmo()) ? 0 : waited + 1;
         outstanding <= (next_owner() != owner || s_ready || m_tmo()) ? 1'b0
                      : (m_strobe() ? 1'b1 : outstanding);
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("gnt%0d", i), {31'b0, gnt[i]}, {31'b0, owner == i});
            chk($sformatf("hrd%0d", i), {31'b0, hrd[i]},
                {31'b0, owner == i && req[1-i] && !outstanding && !(m_strobe() && !s_ready)});
            chk($sformatf("ready%0d", i), {31'b0, ready[i]},
                {31'b0, owner == i && (s_ready || m_tmo())});
            chk($sformatf("spo%0d", i), spo[i], (owner == i && !m_tmo()) ? s_spo : 32'h0);
         end
         chk("s_a", s_a, m_addr());
         chk("s_d", s_d, (owner < 0) ? 32'h0 : d[owner]);
         chk("s_we", {31'b0, s_we}, {31'b0, owner >= 0 && we[owner] && !m_tmo()});
         chk("s_rd", {31'b0, s_rd}, {31'b0, owner >= 0 && rd[owner] && !m_tmo()});
         chk("bus_err", {31'b0, bus_err}, {31'b0, err_pulse});
         chk("err_addr", err_addr, err_a);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; rd[i] = 1'b0; a[i] = '0; d[i] = '0;
      end
      s_spo = '0; s_ready = 1'b0;
      cyc(); cyc();
      neg();
      chk("rst_gnt0", {31'b0, gnt[0]}, 32'd0);
      chk("rst_gnt1", {31'b0, gnt[1]}, 32'd0);
      chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);

      // m1 alone: grant latency and a 3-wait-cycle read
      cyc(); rst = 1'b0; req[1] = 1'b1;
      neg(); chk("t1_gnt_latency", {31'b0, gnt[1]}, 32'd0);
      cyc(); neg(); chk("t1_gnt", {31'b0, gnt[1]}, 32'd1);
      cyc(); rd[1] = 1'b1; a[1] = 32'h8000_1000;
      neg(); chk("t1_s_rd", {31'b0, s_rd}, 32'd1); chk("t1_s_a", s_a, 32'h8000_1000);
      cyc(); cyc();
      neg(); chk("t1_wait", {31'b0, ready[1]}, 32'd0);
      cyc(); s_ready = 1'b1; s_spo = 32'hDEAD_BEEF;
      neg(); chk("t1_ready", {31'b0, ready[1]}, 32'd1); chk("t1_spo", spo[1], 32'hDEAD_BEEF);
      cyc(); rd[1] = 1'b0; s_ready = 1'b0; s_spo = '0;
      neg(); chk("t1_ready_drop", {31'b0, ready[1]}, 32'd0);
      cyc(); req[1] = 1'b0;

      // simultaneous request, HIPRIO=0, then direct handoff
      cyc(); req[0] = 1'b1; req[1] = 1'b1;
      neg(); chk("t2_idle", {31'b0, gnt[0]}, 32'd0);
      cyc(); neg();
      chk("t2_gnt0", {31'b0, gnt[0]}, 32'd1); chk("t2_gnt1", {31'b0, gnt[1]}, 32'd0);
      chk("t2_hrd0", {31'b0, hrd[0]}, 32'd1);
      cyc(); req[0] = 1'b0;
      neg(); chk("t2_hold", {31'b0, gnt[0]}, 32'd1);
      cyc(); neg();
      chk("t2_handoff1", {31'b0, gnt[1]}, 32'd1); chk("t2_handoff0", {31'b0, gnt[0]}, 32'd0);

      // write in flight suppresses hrd until completion
      cyc(); we[1] = 1'b1; a[1] = 32'h0000_0010; d[1] = 32'hCAFE_F00D;
      neg(); chk("t3_s_we", {31'b0, s_we}, 32'd1); chk("t3_s_d", s_d, 32'hCAFE_F00D);
      cyc(); req[0] = 1'b1;
      neg(); chk("t3_hrd_pend", {31'b0, hrd[1]}, 32'd0);
      cyc(); neg(); chk("t3_hrd_busy", {31'b0, hrd[1]}, 32'd0);
      cyc(); s_ready = 1'b1;
      neg(); chk("t3_ready", {31'b0, ready[1]}, 32'd1); chk("t3_hrd_rdy", {31'b0, hrd[1]}, 32'd0);
      cyc(); we[1] = 1'b0; s_ready = 1'b0;
      neg(); chk("t3_hrd_free", {31'b0, hrd[1]}, 32'd1); chk("t3_hrd0", {31'b0, hrd[0]}, 32'd0);
      cyc(); req[1] = 1'b0;
      neg(); chk("t3_hold", {31'b0, gnt[1]}, 32'd1);
      cyc(); neg(); chk("t3_gnt0", {31'b0, gnt[0]}, 32'd1); chk("t3_gnt1", {31'b0, gnt[1]}, 32'd0);

      // fairness: owner blips req low while the other waits
      cyc(); req[1] = 1'b1;
      neg(); chk("t6_hrd0", {31'b0, hrd[0]}, 32'd1);
      cyc(); req[0] = 1'b0;
      cyc(); req[0] = 1'b1;
      neg(); chk("t6_gnt1", {31'b0, gnt[1]}, 32'd1); chk("t6_gnt0", {31'b0, gnt[0]}, 32'd0);
      chk("t6_hrd1", {31'b0, hrd[1]}, 32'd1);
      cyc(); req[0] = 1'b0;

      // hung read terminated by the watchdog at strobe cycle 16
      cyc(); rd[1] = 1'b1; a[1] = 32'h4000_0000; s_spo = 32'h1234_5678;
      neg(); chk("t4_s_rd", {31'b0, s_rd}, 32'd1);
      for (int k = 2; k <= 15; k++) cyc();
      neg(); chk("t4_pre", {31'b0, ready[1]}, 32'd0);
      cyc(); neg();
      chk("t4_ready", {31'b0, ready[1]}, 32'd1); chk("t4_s_rd_kill", {31'b0, s_rd}, 32'd0);
      chk("t4_spo", spo[1], 32'd0); chk("t4_err_early", {31'b0, bus_err}, 32'd0);
      cyc(); rd[1] = 1'b0;
      neg(); chk("t4_bus_err", {31'b0, bus_err}, 32'd1); chk("t4_err_addr", err_addr, 32'h4000_0000);
      cyc(); neg(); chk("t4_err_pulse", {31'b0, bus_err}, 32'd0);

      // ready in the timeout cycle is a normal completion
      cyc(); rd[1] = 1'b1; a[1] = 32'h4000_0040;
      for (int k = 2; k <= 15; k++) cyc();
      cyc(); s_ready = 1'b1; s_spo = 32'hA5A5_A5A5;
      neg();
      chk("t4b_spo", spo[1], 32'hA5A5_A5A5); chk("t4b_s_rd", {31'b0, s_rd}, 32'd1);
      chk("t4b_ready", {31'b0, ready[1]}, 32'd1);
      cyc(); rd[1] = 1'b0; s_ready = 1'b0;
      neg(); chk("t4b_no_err", {31'b0, bus_err}, 32'd0); chk("t4b_err_addr", err_addr, 32'h4000_0000);

      // reset mid-read, then re-request
      cyc(); rd[1] = 1'b1; a[1] = 32'h8000_2000;
      neg(); chk("t5_s_rd", {31'b0, s_rd}, 32'd1);
      cyc(); rst = 1'b1;
      cyc(); s_ready = 1'b1;
      neg();
      chk("t5_gnt", {31'b0, gnt[1]}, 32'd0); chk("t5_ready", {31'b0, ready[1]}, 32'd0);
      chk("t5_s_rd0", {31'b0, s_rd}, 32'd0); chk("t5_s_a", s_a, 32'd0);
      chk("t5_err_addr", err_addr, 32'd0);
      cyc(); rst = 1'b0; s_ready = 1'b0;
      neg(); chk("t5_idle", {31'b0, gnt[1]}, 32'd0);
      cyc(); neg();
      chk("t5_regnt", {31'b0, gnt[1]}, 32'd1); chk("t5_s_a2", s_a, 32'h8000_2000);
      cyc(); s_ready = 1'b1; s_spo = 32'h0BAD_F00D;
      neg(); chk("t5_ready2", {31'b0, ready[1]}, 32'd1); chk("t5_spo2", spo[1], 32'h0BAD_F00D);
      cyc(); rd[1] = 1'b0; s_ready = 1'b0; s_spo = '0; req[1] = 1'b0;
      cyc(); cyc();
      neg();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter2.md
# bus_arbiter2

Two-master physical-bus arbiter that sits directly downstream of `mmu_sv32`'s physical port (`preq/pgnt/phrd/pa/pd/pwe/prd/pspo/pready`) and upstream of the memory/peripheral interconnect. It grants the single slave bus to the CPU-side master (through the MMU) or a secondary master (DMA/video). Arbitration is fixed-priority with transfer-boundary handoff via `hrd`. A per-transfer timeout watchdog turns a hung slave into a terminated transfer plus an error pulse.

## Interface
Parameters:
- `TIMEOUT`, 1024: cycles a strobe may wait for `s_ready` before forced termination; minimum 2.
- `HIPRIO`, 0: index of the master that wins simultaneous requests from IDLE.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `m0_req`  in  1  master 0 requests bus
- `m0_gnt`  out  1  master 0 owns bus
- `m0_hrd`  out  1  other master waiting; owner drops req at next transfer boundary
- `m0_a`  in  32  address
- `m0_d`  in  32  write data
- `m0_we`  in  1  write strobe
- `m0_rd`  in  1  read strobe
- `m0_spo`  out  32  read data
- `m0_ready`  out  1  transfer complete
- `m1_*`  same widths and directions as `m0_*`; CPU/MMU side
- `s_a`  out  32  slave address
- `s_d`  out  32  slave write data
- `s_we`  out  1  slave write strobe
- `s_rd`  out  1  slave read strobe
- `s_spo`  in  32  slave read data
- `s_ready`  in  1  slave done
- `bus_err`  out  1  one-cycle pulse on timeout
- `err_addr`  out  32  `s_a` captured at last timeout

## Operation
- States: IDLE, GNT0, GNT1.
- IDLE:
  - exactly one req high → grant that master;
  - both high → grant `HIPRIO`;
  - neither → stay.
- GNTx with `mx_req` low:
  - other req high → GNTy directly, no IDLE cycle;
  - else → IDLE.
- GNTx with `mx_req` high: stay. The bus is never revoked while the owner requests.
- Fairness: owner drops req for one cycle while the other waits → the other wins, even if the owner re-raises req that same cycle.
- `mx_hrd` = (state==GNTx) & other req & !busy. Never asserted to a non-owner. Held low during an outstanding transfer.
- Routing:
  - GNTx: `s_a/s_d/s_we/s_rd` driven from master x.
  - IDLE: all `s_*` outputs 0.
  - `mx_spo` = `s_spo` when owner x, else 0.
  - `mx_ready` = (owner x) & (`s_ready` | tmo).
- busy:
  - set when the owner's (we|rd) is high and `s_ready` is low;
  - cleared on `s_ready` or tmo.
- Watchdog:
  - counter increments each cycle the routed strobe is high and `s_ready` is low;
  - clears on `s_ready`, strobe low, grant change, or tmo.
  - Counter == `TIMEOUT-1` → tmo for one cycle: `s_we/s_rd` forced 0, owner gets `mx_ready`=1 with `mx_spo`=0, `bus_err`=1, `err_addr` ← `s_a`.
- Data is passed unmodified. Byte order is the masters' concern.

## Timing
- Grant latency: req seen in IDLE → `gnt` high next cycle. Strobes are only forwarded once `gnt` is high.
- Handoff: owner req low at edge N → other master's `gnt` high after edge N+1. `s_*` is never driven by both masters in one cycle.
- `mx_ready` and `mx_spo` are combinational from `s_ready`/`s_spo` (zero added latency). `mx_hrd` is combinational.
- `bus_err` is registered: it is high the cycle after tmo and lasts exactly 1 cycle. `err_addr` updates on the same edge.
- Reset values: state IDLE; all `gnt`, `hrd`, `ready`, `spo`, `s_*` = 0; `bus_err` = 0; `err_addr` = 0; counter 0; busy 0.
- Reset mid-transfer: all of the above hold from the first edge with `rst` high. No ready is issued for the aborted transfer.
- `s_ready` arriving in the tmo cycle counts as a normal completion: no error, real `s_spo` passed through.

## Structure
- Shared package holds:
  - state encoding `ARB_IDLE=0`, `ARB_GNT0=1`, `ARB_GNT1=2`;
  - default `ARB_TIMEOUT`;
  - helper constant for counter width, `$clog2(TIMEOUT)`.
- One natural sub-module: `bus_timeout`, the watchdog counter. Inputs: strobe, `s_ready`, clear. Output: tmo pulse.

## Test plan
- m1 alone: req → `m1_gnt` next cycle; read 0x80001000 with `s_ready` after 3 cycles, `s_spo`=0xDEADBEEF → `m1_ready` 1 cycle, `m1_spo`=0xDEADBEEF.
- Both req in IDLE, `HIPRIO`=0 → `m0_gnt`, `m1_gnt` stays 0. m0 drops req → `m1_gnt` on the next edge, with no IDLE cycle.
- m1 owns bus with a write in flight, m0 raises req → `m1_hrd`=0 until `s_ready`, then `m1_hrd`=1. m1 drops req → handoff to m0.
- Read 0x40000000 with `s_ready` never asserted, `TIMEOUT`=16 → `m1_ready`=1 and `s_rd`=0 at strobe cycle 16, `m1_spo`=0, `bus_err` pulse, `err_addr`=0x40000000.
- `rst` pulsed mid-read → all outputs 0 after the edge, state IDLE, no spurious ready. Re-request succeeds normally.
- Owner drops req for 1 cycle while the other waits → the other is granted even though the owner re-raised req.
